// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared types and constants for the hazard / forwarding controller.
package hazard_fwd_ctrl_pkg;

  typedef logic [1:0] fwd_sel_t;

  // Operand mux selects seen by the EX stage.
  localparam fwd_sel_t FWD_DATA = 2'b00;
  localparam fwd_sel_t FWD_EX   = 2'b01;
  localparam fwd_sel_t FWD_MEM  = 2'b10;

  // Register 0 is hard-wired and never a forwarding or stall source.
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// ID-stage request bundle plus the controller's responses.
interface hazard_fwd_ctrl_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_rs_used;
  logic             id_rt_used;
  logic [REG_W-1:0] id_rd;
  logic             id_regwrite;
  logic             id_memread;
  logic             br_flush;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             stall;
  logic             bubble;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd,
           id_regwrite, id_memread, br_flush,
    input  fwd_a_sel, fwd_b_sel, stall, bubble, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd,
           id_regwrite, id_memread, br_flush,
    output fwd_a_sel, fwd_b_sel, stall, bubble, stall_count
  );
endinterface

// File: rtl/hazard_fwd_ctrl_fwd_compare.sv
// Forwarding select for one EX operand; the nearer (EX) producer wins.
module fwd_compare
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic [REG_W-1:0] src,
  input  logic             used,
  input  logic             ex_wr,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_wr,
  input  logic [REG_W-1:0] mem_rd,
  output fwd_sel_t         sel
);

  // ex_wr / mem_wr already exclude r0, so a match here is always real.
  always_comb begin
    sel = FWD_DATA;
    if (used && ex_wr && (src == ex_rd))
      sel = FWD_EX;
    else if (used && mem_wr && (src == mem_rd))
      sel = FWD_MEM;
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and EX operand forwarding control for the 5-stage pipeline.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  hazard_fwd_ctrl_if.slave  bus
);

  logic             ex_v, ex_rw, ex_mr;
  logic [REG_W-1:0] ex_rd;
  logic             mem_v, mem_rw;
  logic [REG_W-1:0] mem_rd;
  logic             ex_wr, mem_wr, load_use, issue;
  fwd_sel_t         sel_a, sel_b;
  fsm_state_t       state;
  logic [CNT_W-1:0] cnt;

  // Effective writes, load-use detection and the issue decision.
  always_comb begin
    ex_wr    = ex_v & ex_rw & (ex_rd != REG_W'(REG_ZERO));
    mem_wr   = mem_v & mem_rw & (mem_rd != REG_W'(REG_ZERO));
    load_use = bus.id_valid & ~bus.br_flush & ex_v & ex_mr &
               (ex_rd != REG_W'(REG_ZERO)) &
               ((bus.id_rs_used & (bus.id_rs == ex_rd)) |
                (bus.id_rt_used & (bus.id_rt == ex_rd)));
    issue    = bus.id_valid & ~load_use & ~bus.br_flush;
  end

  assign bus.stall       = load_use;
  assign bus.bubble      = load_use;
  assign bus.stall_count = cnt;

  fwd_compare #(.REG_W(REG_W)) u_cmp_a (
    .src(bus.id_rs), .used(bus.id_rs_used),
    .ex_wr(ex_wr), .ex_rd(ex_rd), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .sel(sel_a)
  );

  fwd_compare #(.REG_W(REG_W)) u_cmp_b (
    .src(bus.id_rt), .used(bus.id_rt_used),
    .ex_wr(ex_wr), .ex_rd(ex_rd), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .sel(sel_b)
  );

  // Shadow EX/MEM destination info; a non-issued slot enters EX invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v   <= 1'b0;
      ex_rw  <= 1'b0;
      ex_mr  <= 1'b0;
      ex_rd  <= '0;
      mem_v  <= 1'b0;
      mem_rw <= 1'b0;
      mem_rd <= '0;
    end else begin
      mem_v  <= ex_v;
      mem_rw <= ex_rw;
      mem_rd <= ex_rd;
      ex_v   <= issue;
      ex_rw  <= bus.id_regwrite;
      ex_mr  <= bus.id_memread;
      ex_rd  <= bus.id_rd;
    end
  end

  // Selects follow the consumer into EX; bubbles and squashes get 00.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.fwd_a_sel <= FWD_DATA;
      bus.fwd_b_sel <= FWD_DATA;
    end else if (issue) begin
      bus.fwd_a_sel <= sel_a;
      bus.fwd_b_sel <= sel_b;
    end else begin
      bus.fwd_a_sel <= FWD_DATA;
      bus.fwd_b_sel <= FWD_DATA;
    end
  end

  // One stall cycle per load: the bubble behind it rules out a second one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_RUN;
    else if (state == ST_RUN && load_use)
      state <= ST_HOLD;
    else
      state <= ST_RUN;
  end

  hold_no_stall: assert property (@(posedge clk) disable iff (!rst_n)
                                  (state == ST_HOLD) |-> !load_use);

  // Saturating count of load-use stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (load_use && (cnt != '1))
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench: directed pipeline scenarios plus randomized traffic
// checked every cycle against a history-based model of the pipeline.
module tb_hazard_fwd_ctrl;

  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl_if #(.REG_W(5), .CNT_W(CW)) bus ();

  hazard_fwd_ctrl #(.REG_W(5), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // Model: what instruction sits in EX and in MEM, as plain records.
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mr;
  } instr_t;

  instr_t in_ex, in_mem;
  int     exp_a = 0, exp_b = 0, exp_cnt = 0;

  function automatic bit writes(input instr_t i, input int r);
    return i.v && i.rw && i.rd != 0 && i.rd == r;
  endfunction

  function automatic bit model_hazard();
    bit reads_load;
    if (!bus.id_valid || bus.br_flush) return 1'b0;
    if (!(in_ex.v && in_ex.mr && in_ex.rd != 0)) return 1'b0;
    reads_load = (bus.id_rs_used && int'(bus.id_rs) == in_ex.rd) ||
                 (bus.id_rt_used && int'(bus.id_rt) == in_ex.rd);
    return reads_load;
  endfunction

  function automatic int model_sel(input int src, input bit used);
    if (!used) return 0;
    if (writes(in_ex, src)) return 1;
    if (writes(in_mem, src)) return 2;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ex   = '{0, 0, 0, 0};
      in_mem  = '{0, 0, 0, 0};
      exp_a   = 0;
      exp_b   = 0;
      exp_cnt = 0;
    end else begin
      bit h, iss;
      h   = model_hazard();
      iss = bus.id_valid && !bus.br_flush && !h;
      exp_a = iss ? model_sel(int'(bus.id_rs), bus.id_rs_used) : 0;
      exp_b = iss ? model_sel(int'(bus.id_rt), bus.id_rt_used) : 0;
      if (h && exp_cnt < CMAX) exp_cnt++;
      in_mem = in_ex;
      in_ex  = iss ? '{1, int'(bus.id_rd), bus.id_regwrite, bus.id_memread}
                   : '{0, 0, 0, 0};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, mid-cycle, DUT versus model.
  always @(negedge clk) begin
    bit h;
    h = model_hazard();
    check("model_stall",  32'(bus.stall),       int'(h));
    check("model_bubble", 32'(bus.bubble),      int'(h));
    check("model_fwd_a",  32'(bus.fwd_a_sel),   exp_a);
    check("model_fwd_b",  32'(bus.fwd_b_sel),   exp_b);
    check("model_count",  32'(bus.stall_count), exp_cnt);
  end

  task automatic drive(input bit v, input int rs, input int rt, input bit rsu,
                       input bit rtu, input int rd, input bit rw, input bit mr,
                       input bit fl);
    @(posedge clk);
    #1;
    bus.id_valid    = v;
    bus.id_rs       = 5'(rs);
    bus.id_rt       = 5'(rt);
    bus.id_rs_used  = rsu;
    bus.id_rt_used  = rtu;
    bus.id_rd       = 5'(rd);
    bus.id_regwrite = rw;
    bus.id_memread  = mr;
    bus.br_flush    = fl;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ALU op rd <- rs op rt, load rd <- mem[rs], consumer reading rs/rt.
  task automatic alu(input int rd, input int rs, input int rt);
    drive(1, rs, rt, 1, 1, rd, 1, 0, 0);
  endtask

  task automatic load(input int rd, input int rs);
    drive(1, rs, 0, 1, 0, rd, 1, 1, 0);
  endtask

  initial begin
    bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_rs_used = 0;
    bus.id_rt_used = 0; bus.id_rd = 0; bus.id_regwrite = 0;
    bus.id_memread = 0; bus.br_flush = 0;
    repeat (2) @(negedge clk);
    check("reset_fwd_a", 32'(bus.fwd_a_sel), 0);
    check("reset_count", 32'(bus.stall_count), 0);
    rst_n = 1'b1;

    // lw r8 then add r9,r8,r8: one stall cycle, then both sels from MEM/WB.
    idle();
    load(8, 1);
    alu(9, 8, 8);
    check("lu_stall", 32'(bus.stall), 1);
    check("lu_bubble", 32'(bus.bubble), 1);
    alu(9, 8, 8);
    check("lu_stall_once", 32'(bus.stall), 0);
    idle();
    check("lu_fwd_a", 32'(bus.fwd_a_sel), 2);
    check("lu_fwd_b", 32'(bus.fwd_b_sel), 2);
    check("lu_count", 32'(bus.stall_count), 1);

    // add r3,r1,r2 ; sub r4,r3,r5
    idle(); idle();
    alu(3, 1, 2);
    alu(4, 3, 5);
    check("exfwd_nostall", 32'(bus.stall), 0);
    idle();
    check("exfwd_a", 32'(bus.fwd_a_sel), 1);
    check("exfwd_b", 32'(bus.fwd_b_sel), 0);

    // add r3 ; nop ; or r6,r7,r3
    idle(); idle();
    alu(3, 1, 2);
    idle();
    alu(6, 7, 3);
    idle();
    check("memfwd_a", 32'(bus.fwd_a_sel), 0);
    check("memfwd_b", 32'(bus.fwd_b_sel), 2);

    // add r3 ; sub r3 ; and r10,r3,r3 : the younger producer wins.
    idle(); idle();
    alu(3, 1, 2);
    alu(3, 4, 5);
    alu(10, 3, 3);
    idle();
    check("young_a", 32'(bus.fwd_a_sel), 1);
    check("young_b", 32'(bus.fwd_b_sel), 1);

    // Writes to r0 are never forwarded; a load to r0 never stalls.
    idle(); idle();
    alu(0, 1, 2);
    load(0, 1);
    alu(5, 0, 0);
    check("r0_nostall", 32'(bus.stall), 0);
    idle();
    check("r0_a", 32'(bus.fwd_a_sel), 0);
    check("r0_b", 32'(bus.fwd_b_sel), 0);

    // Flush beats stall: squashed consumer enters EX invalid.
    idle(); idle();
    load(8, 1);
    drive(1, 8, 8, 1, 1, 9, 1, 0, 1);
    check("flush_nostall", 32'(bus.stall), 0);
    alu(11, 1, 2);
    check("flush_sq_a", 32'(bus.fwd_a_sel), 0);
    idle();
    check("flush_next_a", 32'(bus.fwd_a_sel), 0);
    check("flush_next_b", 32'(bus.fwd_b_sel), 0);

    // Saturation of the stall counter.
    repeat (20) begin
      load(8, 1);
      alu(9, 8, 0);
      alu(9, 8, 0);
    end
    idle();
    check("sat_count", 32'(bus.stall_count), CMAX);

    // Reset in the middle of a stall cycle.
    idle(); idle();
    load(8, 1);
    alu(9, 8, 8);
    check("rst_pre_stall", 32'(bus.stall), 1);
    rst_n = 1'b0;
    #1;
    check("rst_stall", 32'(bus.stall), 0);
    check("rst_bubble", 32'(bus.bubble), 0);
    check("rst_a", 32'(bus.fwd_a_sel), 0);
    check("rst_b", 32'(bus.fwd_b_sel), 0);
    check("rst_count", 32'(bus.stall_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    alu(3, 1, 2);
    alu(4, 3, 5);
    idle();
    check("post_rst_a", 32'(bus.fwd_a_sel), 1);

    // Randomized traffic on a small register set to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      if (model_hazard() && $urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #2;
      end else begin
        drive($urandom_range(0, 9) < 8, $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, $urandom_range(0, 3),
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 9) == 0);
      end
    end

    idle(); idle();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
